// File: rtl/song_pkg.sv
// Shared types and constants for the song reader: note word layout,
// end-of-song marker, reader FSM states and the built-in song image.
package song_pkg;

  localparam int WORD_W = 16;

  // note word {advance, note[5:0], duration[5:0], rsvd[2:0]}
  localparam int ADV_BIT  = 15;
  localparam int NOTE_MSB = 14;
  localparam int NOTE_LSB = 9;
  localparam int DUR_MSB  = 8;
  localparam int DUR_LSB  = 3;

  localparam logic [WORD_W-1:0] END_MARKER = 16'h0000;

  typedef enum logic [2:0] {
    PAUSED, FETCH, WAIT_ROM, CHECK, ISSUE, WAIT_NOTE, NEXT, DONE
  } state_e;

  function automatic logic [WORD_W-1:0] mk_note(logic adv, logic [5:0] note, logic [5:0] dur);
    logic [WORD_W-1:0] w;
    w                   = '0;
    w[ADV_BIT]          = adv;
    w[NOTE_MSB:NOTE_LSB] = note;
    w[DUR_MSB:DUR_LSB]   = dur;
    return w;
  endfunction

  // Per-song init table. Song 0/1 are short tunes terminated by the end
  // marker, song 2 fills every slot (never hits a marker), song 3 is empty.
  function automatic logic [WORD_W-1:0] rom_image(int song, int idx);
    logic [31:0]       iv;
    logic [WORD_W-1:0] w;
    iv = idx;
    w  = END_MARKER;
    case (song)
      0: case (idx)
           0: w = mk_note(1'b0, 6'd42, 6'd63);
           1: w = mk_note(1'b1, 6'd0,  6'd3);
           default: w = END_MARKER;
         endcase
      1: case (idx)
           0: w = mk_note(1'b0, 6'd21, 6'd8);
           1: w = mk_note(1'b0, 6'd30, 6'd10);
           2: w = mk_note(1'b0, 6'd39, 6'd12);
           3: w = mk_note(1'b1, 6'd48, 6'd14);
           default: w = END_MARKER;
         endcase
      2: w = {1'b1, 2'b00, iv[6:0], 6'd0};
      default: w = END_MARKER;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Registered-output song ROM, address {song, index}, one cycle read latency.
module song_rom import song_pkg::*; #(
  parameter int SONG_BITS      = 2,
  parameter int NOTE_ADDR_BITS = 7
) (
  input  logic                                clk,
  input  logic [SONG_BITS+NOTE_ADDR_BITS-1:0] addr_i,
  output logic [WORD_W-1:0]                   data_o
);

  localparam int SONG_WORDS = 2 ** NOTE_ADDR_BITS;
  localparam int DEPTH      = 2 ** (SONG_BITS + NOTE_ADDR_BITS);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] data_q;

  for (genvar a = 0; a < DEPTH; a++) begin : g_img
    assign mem[a] = rom_image(a / SONG_WORDS, a % SONG_WORDS);
  end

  // registered read port
  always_ff @(posedge clk) begin
    data_q <= mem[addr_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the song ROM one note word at a time, strobes each
// word to the arranger and waits for note_done before fetching the next.
// Optional macro SONG_LOOP_EN: restart the song from word 0 after the end
// instead of parking in PAUSED.
module song_reader #(
  parameter int SONG_BITS      = 2,
  parameter int NOTE_ADDR_BITS = 7,
  parameter int WORD_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 note_done,
  output logic                 load_new_note,
  output logic [WORD_W-1:0]    note_to_load,
  output logic                 song_done
);
  import song_pkg::*;

  localparam logic [NOTE_ADDR_BITS-1:0] LAST_IDX = '1;

  state_e                    state_q, state_d;
  logic [NOTE_ADDR_BITS-1:0] index_q, index_d;
  logic [WORD_W-1:0]         note_q, note_d;
  logic [SONG_BITS-1:0]      song_q;
  logic                      hold_q, hold_d;
  logic [WORD_W-1:0]         rom_data;
  logic                      song_chg;

  assign song_chg = (song != song_q);

  song_rom #(
    .SONG_BITS      (SONG_BITS),
    .NOTE_ADDR_BITS (NOTE_ADDR_BITS)
  ) u_rom (
    .clk    (clk),
    .addr_i ({song_q, index_q}),
    .data_o (rom_data)
  );

  // state, index, held note word and song tracking registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PAUSED;
      index_q <= '0;
      note_q  <= '0;
      hold_q  <= 1'b0;
      song_q  <= song;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      note_q  <= note_d;
      hold_q  <= hold_d;
      song_q  <= song;
    end
  end

  // next-state logic; hold_q parks a finished song until play is released
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    note_d  = note_q;
    hold_d  = hold_q;
    if (!play) hold_d = 1'b0;
    case (state_q)
      PAUSED:    if (play && !hold_q) state_d = FETCH;
      FETCH:     state_d = WAIT_ROM;
      WAIT_ROM:  state_d = CHECK;
      // ROM address is held, so the word stays valid while paused here
      CHECK: begin
        if (rom_data == END_MARKER) begin
          state_d = DONE;
        end else if (play) begin
          state_d = ISSUE;
          note_d  = rom_data;
        end
      end
      ISSUE:     state_d = WAIT_NOTE;
      WAIT_NOTE: if (note_done) state_d = NEXT;
      NEXT: begin
        if (index_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          index_d = index_q + 1'b1;
          state_d = play ? FETCH : PAUSED;
        end
      end
      DONE: begin
        index_d = '0;
`ifdef SONG_LOOP_EN
        state_d = play ? FETCH : PAUSED;
`else
        state_d = PAUSED;
        hold_d  = play;
`endif
      end
      default: state_d = PAUSED;
    endcase
    // a new song selection restarts from the top and overrides everything
    if (song_chg) begin
      state_d = PAUSED;
      index_d = '0;
      hold_d  = 1'b0;
    end
  end

  assign load_new_note = (state_q == ISSUE) && !song_chg;
  assign song_done     = (state_q == DONE)  && !song_chg;
  assign note_to_load  = note_q;

endmodule

// File: tb/tb_song_reader.sv
// Directed bench for song_reader against the built-in song image.
module tb_song_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        play;
  logic [1:0]  song;
  logic        note_done;
  logic        load_new_note;
  logic [15:0] note_to_load;
  logic        song_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  song_reader #(.SONG_BITS(2), .NOTE_ADDR_BITS(7), .WORD_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .song          (song),
    .note_done     (note_done),
    .load_new_note (load_new_note),
    .note_to_load  (note_to_load),
    .song_done     (song_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] s);
    reset = 1'b1; play = 1'b0; song = s; note_done = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;
    repeat (4) tick();
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL reset_load got %b want 0", load_new_note); end
    checks++; if (note_to_load !== 16'h0000) begin failures++; $display("FAIL reset_note got %h want 0000", note_to_load); end
    checks++; if (song_done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", song_done); end
    reset = 1'b0;
  endtask

  // play from reset: strobe on the 4th edge, then silence until note_done
  task automatic test_first_note();
    int n;
    play = 1'b1;
    repeat (3) tick();
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL first_early got %b want 0", load_new_note); end
    tick();
    checks++; if (load_new_note !== 1'b1) begin failures++; $display("FAIL first_strobe got %b want 1", load_new_note); end
    checks++; if (note_to_load !== 16'h55F8) begin failures++; $display("FAIL first_word got %h want 55F8", note_to_load); end
    n = 0;
    repeat (20) begin tick(); if (load_new_note) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL first_single got %0d extra strobes want 0", n); end
    checks++; if (note_to_load !== 16'h55F8) begin failures++; $display("FAIL first_hold got %h want 55F8", note_to_load); end
  endtask

  task automatic test_second_note();
    note_done = 1'b1; tick(); note_done = 1'b0;
    repeat (3) tick();
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL second_early got %b want 0", load_new_note); end
    tick();
    checks++; if (load_new_note !== 1'b1) begin failures++; $display("FAIL second_strobe got %b want 1", load_new_note); end
    checks++; if (note_to_load !== 16'h8018) begin failures++; $display("FAIL second_word got %h want 8018", note_to_load); end
  endtask

  task automatic test_end_of_song();
    int n;
    tick();
    note_done = 1'b1; tick(); note_done = 1'b0;
    n = 0;
    repeat (3) begin tick(); if (load_new_note || song_done) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL eos_quiet got %0d events want 0", n); end
    tick();
    checks++; if (song_done !== 1'b1) begin failures++; $display("FAIL eos_done got %b want 1", song_done); end
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL eos_nostrobe got %b want 0", load_new_note); end
    tick();
    checks++; if (song_done !== 1'b0) begin failures++; $display("FAIL eos_pulse got %b want 0", song_done); end
`ifdef SONG_LOOP_EN
    repeat (3) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h55F8) begin failures++; $display("FAIL eos_loop got %b/%h want 1/55F8", load_new_note, note_to_load); end
`else
    n = 0;
    repeat (12) begin tick(); if (load_new_note || song_done) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL eos_idle got %0d events want 0", n); end
`endif
  endtask

  task automatic test_pause_in_wait_note();
    int n;
    do_reset(2'd1);
    play = 1'b1;
    repeat (4) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h2A40) begin failures++; $display("FAIL pause_first got %b/%h want 1/2A40", load_new_note, note_to_load); end
    tick();
    play = 1'b0;
    repeat (2) tick();
    note_done = 1'b1; tick(); note_done = 1'b0;
    n = 0;
    repeat (8) begin tick(); if (load_new_note) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL pause_hold got %0d strobes want 0", n); end
    play = 1'b1;
    repeat (4) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h3C50) begin failures++; $display("FAIL pause_resume got %b/%h want 1/3C50", load_new_note, note_to_load); end
  endtask

  task automatic test_song_change();
    int n;
    do_reset(2'd0);
    play = 1'b1;
    repeat (4) tick();
    tick();
    song = 2'd1; play = 1'b0;
    n = 0;
    repeat (3) begin tick(); if (load_new_note || song_done) n++; end
    note_done = 1'b1; tick(); note_done = 1'b0;
    repeat (5) begin tick(); if (load_new_note || song_done) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL chg_quiet got %0d events want 0", n); end
    play = 1'b1;
    repeat (4) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h2A40) begin failures++; $display("FAIL chg_newsong got %b/%h want 1/2A40", load_new_note, note_to_load); end
  endtask

  task automatic test_song_change_at_issue();
    do_reset(2'd0);
    play = 1'b1;
    repeat (4) tick();
    song = 2'd1;
    #1;
    checks++; if (load_new_note !== 1'b0) begin failures++; $display("FAIL chg_issue got %b want 0", load_new_note); end
    repeat (5) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h2A40) begin failures++; $display("FAIL chg_issue_restart got %b/%h want 1/2A40", load_new_note, note_to_load); end
  endtask

  // note_done outside WAIT_NOTE is dropped; reset during ISSUE kills the strobe
  task automatic test_spurious_and_reset();
    int n;
    do_reset(2'd1);
    play = 1'b1;
    tick();
    note_done = 1'b1;
    repeat (2) tick();
    note_done = 1'b0;
    tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h2A40) begin failures++; $display("FAIL spur_first got %b/%h want 1/2A40", load_new_note, note_to_load); end
    n = 0;
    repeat (8) begin tick(); if (load_new_note) n++; end
    checks++; if (n !== 0) begin failures++; $display("FAIL spur_latched got %0d strobes want 0", n); end
    note_done = 1'b1; tick(); note_done = 1'b0;
    repeat (4) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h3C50) begin failures++; $display("FAIL spur_second got %b/%h want 1/3C50", load_new_note, note_to_load); end
    reset = 1'b1;
    tick();
    checks++; if (load_new_note !== 1'b0 || note_to_load !== 16'h0000 || song_done !== 1'b0) begin failures++; $display("FAIL rst_issue got %b/%h/%b want 0/0000/0", load_new_note, note_to_load, song_done); end
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (load_new_note !== 1'b1 || note_to_load !== 16'h2A40) begin failures++; $display("FAIL rst_restart got %b/%h want 1/2A40", load_new_note, note_to_load); end
  endtask

  // a song filling every slot ends at the last index without overflowing
  task automatic test_wrap();
    int          strobes;
    logic [15:0] last;
    bit          seen;
    strobes = 0; last = '0; seen = 0;
    do_reset(2'd2);
    play = 1'b1;
    for (int c = 0; c < 3000 && !seen; c++) begin
      tick();
      if (song_done) begin
        seen = 1;
      end else if (load_new_note) begin
        strobes++;
        last = note_to_load;
        tick();
        note_done = 1'b1; tick(); note_done = 1'b0;
      end
    end
    checks++; if (seen !== 1'b1) begin failures++; $display("FAIL wrap_timeout got no song_done want song_done"); end
    checks++; if (strobes !== 128) begin failures++; $display("FAIL wrap_count got %0d want 128", strobes); end
    checks++; if (last !== 16'h9FC0) begin failures++; $display("FAIL wrap_last got %h want 9FC0", last); end
  endtask

  initial begin
    test_reset();
    test_first_note();
    test_second_note();
    test_end_of_song();
    test_pause_in_wait_note();
    test_song_change();
    test_song_change_at_issue();
    test_spurious_and_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
